// File: rtl/cache_mem_arbiter.sv
// Two-master arbiter sharing one memory port between the I-cache and D-cache
// refill/write-back engines: one transaction at a time, round-robin, write before read.
module cache_mem_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  // instruction-cache master
  input  logic                      i_ren,
  input  logic [ADDR_WIDTH-1:0]     i_raddr,
  output logic [DATA_WIDTH*2-1:0]   i_rdata,
  output logic                      i_rvalid,
  input  logic                      i_wen,
  input  logic [ADDR_WIDTH-1:0]     i_waddr,
  input  logic [DATA_WIDTH*2-1:0]   i_wdata,
  input  logic [DATA_WIDTH*2/8-1:0] i_wmask,
  output logic                      i_wvalid,
  // data-cache master
  input  logic                      d_ren,
  input  logic [ADDR_WIDTH-1:0]     d_raddr,
  output logic [DATA_WIDTH*2-1:0]   d_rdata,
  output logic                      d_rvalid,
  input  logic                      d_wen,
  input  logic [ADDR_WIDTH-1:0]     d_waddr,
  input  logic [DATA_WIDTH*2-1:0]   d_wdata,
  input  logic [DATA_WIDTH*2/8-1:0] d_wmask,
  output logic                      d_wvalid,
  // memory port
  output logic                      mem_ren,
  output logic                      mem_wen,
  output logic [ADDR_WIDTH-1:0]     mem_raddr,
  output logic [ADDR_WIDTH-1:0]     mem_waddr,
  output logic [DATA_WIDTH*2-1:0]   mem_wdata,
  output logic [DATA_WIDTH*2/8-1:0] mem_wmask,
  input  logic [DATA_WIDTH*2-1:0]   mem_rdata,
  input  logic                      mem_rvalid,
  input  logic                      mem_wvalid,
  // debug visibility of the FSM
  output logic [1:0]                o_dbg_state,
  output logic                      o_dbg_owner,
  output logic                      o_dbg_last
);

  // Handshake: a master raises ren/wen with stable address/data and holds it
  // until the matching rvalid/wvalid pulse; it drops the strobe the cycle after.
  // Memory strobes stay high from grant through the completion cycle inclusive.

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_t;

  state_t r_state;
  logic   r_owner;
  logic   r_last;

  logic w_i_req;
  logic w_d_req;
  logic w_grant_d;
  logic w_grant_wen;

  assign w_i_req     = i_ren | i_wen;
  assign w_d_req     = d_ren | d_wen;
  // On a tie the master that did not complete last wins.
  assign w_grant_d   = w_d_req & (~w_i_req | (r_last == OWN_I));
  assign w_grant_wen = w_grant_d ? d_wen : i_wen;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_owner <= OWN_D;
      r_last  <= OWN_I;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_i_req | w_d_req) begin
            r_owner <= w_grant_d;
            r_state <= w_grant_wen ? ST_WR : ST_RD;
          end
        end
        ST_RD: begin
          if (mem_rvalid) begin
            r_last  <= r_owner;
            r_state <= ST_IDLE;
          end
        end
        ST_WR: begin
          if (mem_wvalid) begin
            r_last  <= r_owner;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_raddr = '0;
    mem_waddr = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    i_rvalid  = 1'b0;
    i_rdata   = '0;
    i_wvalid  = 1'b0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    d_wvalid  = 1'b0;
    case (r_state)
      ST_RD: begin
        mem_ren   = 1'b1;
        mem_raddr = (r_owner == OWN_D) ? d_raddr : i_raddr;
        if (mem_rvalid) begin
          if (r_owner == OWN_D) begin
            d_rvalid = 1'b1;
            d_rdata  = mem_rdata;
          end else begin
            i_rvalid = 1'b1;
            i_rdata  = mem_rdata;
          end
        end
      end
      ST_WR: begin
        mem_wen   = 1'b1;
        mem_waddr = (r_owner == OWN_D) ? d_waddr : i_waddr;
        mem_wdata = (r_owner == OWN_D) ? d_wdata : i_wdata;
        mem_wmask = (r_owner == OWN_D) ? d_wmask : i_wmask;
        if (mem_wvalid) begin
          d_wvalid = (r_owner == OWN_D);
          i_wvalid = (r_owner == OWN_I);
        end
      end
      default: ;
    endcase
  end

  assign o_dbg_state = r_state;
  assign o_dbg_owner = r_owner;
  assign o_dbg_last  = r_last;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: arbitration order, write-before-read,
// spurious completions, reset abandonment and single-cycle memory completions.
module tb_cache_mem_arbiter;

  localparam int AW = 64;
  localparam int BW = 128;
  localparam int MW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_ren, i_wen, d_ren, d_wen;
  logic [AW-1:0] i_raddr, i_waddr, d_raddr, d_waddr;
  logic [BW-1:0] i_wdata, d_wdata, i_rdata, d_rdata;
  logic [MW-1:0] i_wmask, d_wmask;
  logic          i_rvalid, i_wvalid, d_rvalid, d_wvalid;
  logic          mem_ren, mem_wen, mem_rvalid, mem_wvalid;
  logic [AW-1:0] mem_raddr, mem_waddr;
  logic [BW-1:0] mem_wdata, mem_rdata;
  logic [MW-1:0] mem_wmask;
  logic [1:0]    o_dbg_state;
  logic          o_dbg_owner, o_dbg_last;
  logic          any_out;

  int n_checks = 0;
  int n_pass   = 0;
  int n_pulses;

  // clock/reset block
  always #5 clk = ~clk;

  cache_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .i_ren(i_ren), .i_raddr(i_raddr), .i_rdata(i_rdata), .i_rvalid(i_rvalid),
    .i_wen(i_wen), .i_waddr(i_waddr), .i_wdata(i_wdata), .i_wmask(i_wmask),
    .i_wvalid(i_wvalid),
    .d_ren(d_ren), .d_raddr(d_raddr), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
    .d_wen(d_wen), .d_waddr(d_waddr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_wvalid(d_wvalid),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_raddr(mem_raddr),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .mem_wvalid(mem_wvalid),
    .o_dbg_state(o_dbg_state), .o_dbg_owner(o_dbg_owner), .o_dbg_last(o_dbg_last)
  );

  assign any_out = |{i_rdata, i_rvalid, i_wvalid, d_rdata, d_rvalid, d_wvalid,
                     mem_ren, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_wmask};

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_ren = 0; i_wen = 0; d_ren = 0; d_wen = 0;
    i_raddr = '0; i_waddr = '0; d_raddr = '0; d_waddr = '0;
    i_wdata = '0; d_wdata = '0; i_wmask = '0; d_wmask = '0;
    mem_rvalid = 0; mem_wvalid = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    check("rst_outputs", any_out, 0);
    check("rst_state", o_dbg_state, 0);
    check("rst_last", o_dbg_last, 0);
    check("rst_owner", o_dbg_owner, 1);

    // D reads 0x1000; memory answers in the third busy cycle
    d_ren = 1; d_raddr = 64'h1000;
    step();
    check("t1_mem_ren", mem_ren, 1);
    check("t1_mem_raddr", mem_raddr, 64'h1000);
    check("t1_mem_wen", mem_wen, 0);
    step();
    check("t1_wait_rvalid", d_rvalid, 0);
    step();
    check("t1_ren_held", mem_ren, 1);
    mem_rvalid = 1; mem_rdata = {16{8'hAA}};
    #1;
    check("t1_d_rvalid", d_rvalid, 1);
    check("t1_d_rdata", d_rdata, {16{8'hAA}});
    check("t1_i_rvalid", i_rvalid, 0);
    check("t1_i_rdata", i_rdata, 0);
    step();
    d_ren = 0; mem_rvalid = 0;
    #1;
    check("t1_idle_after", o_dbg_state, 0);
    check("t1_no_second_pulse", d_rvalid, 0);
    check("t1_last_d", o_dbg_last, 1);

    // simultaneous reads right after reset: D first, then I
    do_reset();
    i_ren = 1; i_raddr = 64'h4000; d_ren = 1; d_raddr = 64'h5000;
    step();
    check("t2_first_d", mem_raddr, 64'h5000);
    mem_rvalid = 1; mem_rdata = {8{16'h1111}};
    #1;
    check("t2_d_rvalid", d_rvalid, 1);
    check("t2_i_not_valid", i_rvalid, 0);
    step();
    d_ren = 0; mem_rvalid = 0;
    #1;
    check("t2_dead_cycle", mem_ren, 0);
    step();
    check("t2_second_i", mem_raddr, 64'h4000);
    mem_rvalid = 1; mem_rdata = {8{16'h2222}};
    #1;
    check("t2_i_rvalid", i_rvalid, 1);
    check("t2_i_rdata", i_rdata, {8{16'h2222}});
    step();
    i_ren = 0; mem_rvalid = 0;
    step();
    i_ren = 1; i_raddr = 64'h4100; d_ren = 1; d_raddr = 64'h5100;
    step();
    check("t2_again_d", mem_raddr, 64'h5100);
    mem_rvalid = 1;
    step();
    d_ren = 0; mem_rvalid = 0;
    step();
    check("t2_then_i", mem_raddr, 64'h4100);
    mem_rvalid = 1;
    step();
    i_ren = 0; mem_rvalid = 0;

    // D write+read with concurrent I read: D write, I read, D read
    d_wen = 1; d_waddr = 64'h2000; d_wdata = {4{32'hDEADBEEF}}; d_wmask = 16'hFFFF;
    d_ren = 1; d_raddr = 64'h3000;
    i_ren = 1; i_raddr = 64'h6000;
    step();
    check("t3_wr_first", mem_wen, 1);
    check("t3_no_ren", mem_ren, 0);
    check("t3_waddr", mem_waddr, 64'h2000);
    check("t3_wdata", mem_wdata, {4{32'hDEADBEEF}});
    check("t3_wmask", mem_wmask, 16'hFFFF);
    check("t3_raddr_zero", mem_raddr, 0);
    mem_wvalid = 1;
    #1;
    check("t3_d_wvalid", d_wvalid, 1);
    check("t3_i_wvalid", i_wvalid, 0);
    step();
    d_wen = 0; mem_wvalid = 0;
    step();
    check("t3_i_between", mem_raddr, 64'h6000);
    mem_rvalid = 1; mem_rdata = {8{16'h6666}};
    #1;
    check("t3_i_rvalid", i_rvalid, 1);
    step();
    i_ren = 0; mem_rvalid = 0;
    step();
    check("t3_d_read", mem_raddr, 64'h3000);
    check("t3_d_read_ren", mem_ren, 1);
    mem_rvalid = 1; mem_rdata = {8{16'h3333}};
    #1;
    check("t3_d_rdata", d_rdata, {8{16'h3333}});
    step();
    d_ren = 0; mem_rvalid = 0;

    // spurious completions
    mem_rvalid = 1;
    #1;
    check("t4_idle_rvalid_i", i_rvalid, 0);
    check("t4_idle_rvalid_d", d_rvalid, 0);
    step();
    check("t4_idle_kept", o_dbg_state, 0);
    mem_rvalid = 0;
    d_ren = 1; d_raddr = 64'h7000;
    step();
    mem_wvalid = 1;
    #1;
    check("t4_rd_wvalid_d", d_wvalid, 0);
    check("t4_rd_rvalid_d", d_rvalid, 0);
    step();
    mem_wvalid = 0;
    #1;
    check("t4_rd_kept", o_dbg_state, 1);
    check("t4_rd_addr", mem_raddr, 64'h7000);
    mem_rvalid = 1;
    #1;
    check("t4_real_rvalid", d_rvalid, 1);
    step();
    d_ren = 0; mem_rvalid = 0;

    // reset during a write; late completion is dropped
    d_wen = 1; d_waddr = 64'h8000;
    step();
    check("t5_in_wr", o_dbg_state, 2);
    rst = 1;
    step();
    rst = 0; d_wen = 0; mem_wvalid = 1;
    #1;
    check("t5_outputs_zero", {i_rvalid, i_wvalid, d_rvalid, d_wvalid, mem_ren, mem_wen}, 0);
    check("t5_state_idle", o_dbg_state, 0);
    step();
    check("t5_no_wvalid", d_wvalid, 0);
    check("t5_still_idle", o_dbg_state, 0);
    mem_wvalid = 0;

    // four D reads completing in their first busy cycle
    n_pulses = 0;
    d_ren = 1; d_raddr = 64'h9000; mem_rvalid = 1; mem_rdata = {8{16'h9999}};
    for (int c = 0; c < 8; c++) begin
      step();
      check($sformatf("t6_ren_%0d", c), mem_ren, (c % 2 == 0));
      if (d_rvalid) n_pulses++;
      if (c % 2 == 0)
        check($sformatf("t6_addr_%0d", c), mem_raddr, 64'h9000 + 64'(c / 2) * 64'h10);
      else
        d_raddr = 64'h9000 + 64'((c + 1) / 2) * 64'h10;
      if (c == 7) begin
        d_ren = 0; mem_rvalid = 0;
      end
    end
    step();
    check("t6_pulses", n_pulses, 4);
    check("t6_final_idle", o_dbg_state, 0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
